// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a
// one-entry valid/ready output register with framing-error and overrun pulses.
module uart_rx #(
  parameter int freq = 27_000_000,
  parameter int baud = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       ready,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CPB  = freq / baud;
  localparam int HALF = CPB / 2;
  localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic [1:0]    sync_reg;
  logic          rx_s;
  logic [2:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic [7:0]    data_reg;
  logic          valid_reg;
  logic          frame_err_reg, frame_err_next;
  logic          overrun_reg;
  logic          deliver;
  logic          load;

  // Both stages idle high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) sync_reg <= 2'b11;
    else     sync_reg <= {sync_reg[0], rx};
  end

  assign rx_s = sync_reg[1];

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg + CW'(1);
    bit_next       = bit_reg;
    shift_next     = shift_reg;
    deliver        = 1'b0;
    frame_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (!rx_s) state_next = START;
      end
      START: begin
        if (cnt_reg == HALF_M1) begin
          cnt_next   = '0;
          bit_next   = 3'd0;
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_reg == CPB_M1) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (cnt_reg == CPB_M1) begin
          cnt_next       = '0;
          deliver        = rx_s;
          frame_err_next = !rx_s;
          state_next     = rx_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        // Held-low line must return high before another start can be seen.
        cnt_next = '0;
        if (rx_s) state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign load = deliver && (!valid_reg || ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_reg       <= 3'd0;
      shift_reg     <= 8'd0;
      data_reg      <= 8'd0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_reg       <= bit_next;
      shift_reg     <= shift_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= deliver && valid_reg && !ready;
      if (load) begin
        data_reg  <= shift_reg;
        valid_reg <= 1'b1;
      end else if (valid_reg && ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign data      = data_reg;
  assign valid     = valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at freq=16, baud=2 (8 clocks per bit); the
// bench itself acts as the serial transmitter.
module tb_uart_rx;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int fe_cnt  = 0;
  int ov_cnt  = 0;
  int rise_cnt = 0;
  int last_rise = 0;
  int start_cyc = 0;
  logic valid_prev = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx #(.freq(16), .baud(2)) dut (
    .clk(clk), .rst(rst), .rx(rx), .ready(ready), .data(data),
    .valid(valid), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("[TB] ok   %s: 0x%0h (cycle %0d)", tag, got, cyc);
    end
  endtask

  // Outputs are sampled mid-cycle; a handshake seen here completes on the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid && !valid_prev) begin
        rise_cnt++;
        last_rise = cyc;
      end
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (valid && ready) begin
        if (exp_q.size() == 0) check("unexpected_byte", {24'd0, data}, 32'hFFFF_FFFF);
        else check("rx_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
      end
    end
    valid_prev = valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) step();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic push);
    if (push) exp_q.push_back(b);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, {31'd0, valid}, 32'd0);
    check({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_ovr"}, {31'd0, overrun}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_data"}, {24'd0, data}, 32'd0);
  endtask

  initial begin
    int fe0, ov0, r0, c0;
    rst = 1'b1;
    rx = 1'b1;
    ready = 1'b1;
    repeat (3) step();
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (4) step();

    // Single byte with latency measured from the raw start edge.
    fe0 = fe_cnt; ov0 = ov_cnt; r0 = rise_cnt;
    send_frame(8'h41, 1'b1, 1'b1);
    repeat (4) step();
    check("single_latency", last_rise - start_cyc, 32'd79);
    check("single_rises", rise_cnt - r0, 32'd1);
    check("single_ferr", fe_cnt - fe0, 32'd0);
    check("single_ovr", ov_cnt - ov0, 32'd0);

    // Back-to-back with the consumer stalled: second byte overruns.
    ready = 1'b0;
    ov0 = ov_cnt;
    send_frame(8'h41, 1'b1, 1'b1);
    send_frame(8'h42, 1'b1, 1'b0);
    repeat (4) step();
    check("held_data", {24'd0, data}, 32'h41);
    check("held_valid", {31'd0, valid}, 32'd1);
    check("held_ovr", ov_cnt - ov0, 32'd1);
    ready = 1'b1;
    step();
    check("held_release", {31'd0, valid}, 32'd0);
    repeat (4) step();

    // Three-clock glitch: start check at T+HALF rejects it.
    r0 = rise_cnt; fe0 = fe_cnt;
    c0 = cyc;
    rx = 1'b0;
    repeat (3) step();
    rx = 1'b1;
    while (cyc < c0 + 6) step();
    check("glitch_busy_at_check", {31'd0, busy}, 32'd1);
    step();
    check("glitch_busy_after", {31'd0, busy}, 32'd0);
    repeat (10) step();
    check("glitch_no_valid", rise_cnt - r0, 32'd0);
    check("glitch_no_ferr", fe_cnt - fe0, 32'd0);

    // Framing error followed by a held-low break.
    r0 = rise_cnt; fe0 = fe_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (40) step();
    check("break_busy", {31'd0, busy}, 32'd1);
    check("break_ferr", fe_cnt - fe0, 32'd1);
    check("break_no_valid", rise_cnt - r0, 32'd0);
    rx = 1'b1;
    repeat (4) step();
    check("break_exit", {31'd0, busy}, 32'd0);
    send_frame(8'hA5, 1'b1, 1'b1);
    repeat (4) step();

    // Reset during data bit 4 of 0xFF.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    step();
    check_outputs_zero("midreset");
    rst = 1'b0;
    repeat (4) step();
    for (int i = 5; i < 9; i++) drive_bit(1'b1);
    check("midreset_idle", {31'd0, busy}, 32'd0);
    send_frame(8'h3C, 1'b1, 1'b1);
    repeat (4) step();

    // Loopback-style stream, back-to-back.
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h80, 1'b1, 1'b1);
    send_frame(8'h01, 1'b1, 1'b1);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
    check("drain", exp_q.size(), 32'd0);
    check("loop_ferr", fe_cnt - fe0, 32'd0);
    check("loop_ovr", ov_cnt - ov0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
